lsq_dmem_responder: RTL and testbench

- Data-memory responder on the far end of the LSQ memory port.
- Accepts the one-cycle request pulse (op, address, store data) that the load/store queue drives for the instruction at its head.
- Performs the byte/half/word access on an internal word array after a fixed latency.
- Returns a one-cycle mem_rd_ready (with sign/zero-extended data) or mem_wr_ready pulse; that pulse is what lets the queue retire its head.

---
 rtl/lsq_dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_lsq_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_dmem_responder.sv
// Data-memory responder for the LSQ memory port.
// Takes a one-cycle request pulse, performs a byte/half/word access on an internal
// word array after LATENCY cycles, and answers with a one-cycle ready pulse.
// Overrun, illegal-op and misaligned requests are dropped and flagged on o_err.
module lsq_dmem_responder #(
   parameter int unsigned LATENCY    = 2,   // 1..15
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter string       INIT_FILE  = ""
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [3:0]  i_mem_op,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wr_data,
   output logic        o_mem_rd_ready,
   output logic [31:0] o_mem_rd_data,
   output logic        o_mem_wr_ready,
   output logic        o_busy,
   output logic        o_err
);

   localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
   localparam int unsigned AW     = DEPTH_LOG2 + 2;
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   localparam logic [3:0] OP_LB  = 4'b0001;
   localparam logic [3:0] OP_LH  = 4'b0010;
   localparam logic [3:0] OP_LW  = 4'b0011;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1001;
   localparam logic [3:0] OP_SH  = 4'b1010;
   localparam logic [3:0] OP_SW  = 4'b1011;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e         r_state, w_state_d;
   logic [3:0]     r_cnt, w_cnt_d;
   logic [3:0]     r_op;
   logic [AW-1:0]  r_addr;
   logic [31:0]    r_wdata;
   logic           r_rd_ready, r_wr_ready, r_err;
   logic [31:0]    r_rd_data;

   logic [31:0]    r_mem [DEPTH];

   logic           w_req_ok, w_latch, w_access, w_err_d;
   logic [3:0]     w_acc_op;
   logic [AW-1:0]  w_acc_addr;
   logic [31:0]    w_acc_data;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [1:0]     w_off;
   logic [31:0]    w_word, w_load_val, w_store_word;
   logic [7:0]     w_byte;
   logic [15:0]    w_half;
   logic [3:0]     w_be;
   logic           w_unused_addr;

   // Upper address bits alias onto the array and are deliberately ignored.
   assign w_unused_addr = ^i_mem_addr[31:AW];

   // Classify the incoming request: legal op code with a naturally aligned address.
   always_comb begin
      w_req_ok = 1'b0;
      case (i_mem_op)
         OP_LB, OP_LBU, OP_SB: w_req_ok = 1'b1;
         OP_LH, OP_LHU, OP_SH: w_req_ok = ~i_mem_addr[0];
         OP_LW, OP_SW:         w_req_ok = (i_mem_addr[1:0] == 2'b00);
         default:              w_req_ok = 1'b0;
      endcase
   end

   // Next state, counter, error and access selection.
   always_comb begin
      w_state_d  = r_state;
      w_cnt_d    = r_cnt;
      w_latch    = 1'b0;
      w_access   = 1'b0;
      w_err_d    = 1'b0;
      w_acc_op   = r_op;
      w_acc_addr = r_addr;
      w_acc_data = r_wdata;
      case (r_state)
         StWait: begin
            // Any request while counting is an overrun; the count still completes.
            w_err_d = (i_mem_op != 4'd0);
            if (r_cnt == 4'd0) begin
               w_state_d = StResp;
               w_access  = 1'b1;
            end else begin
               w_cnt_d = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_d = StIdle;
            if (i_mem_op != 4'd0) begin
               if (w_req_ok) begin
                  w_latch = 1'b1;
                  if (LATENCY == 1) begin
                     // Single-cycle latency bypasses WAIT and accesses straight away.
                     w_state_d  = StResp;
                     w_access   = 1'b1;
                     w_acc_op   = i_mem_op;
                     w_acc_addr = i_mem_addr[AW-1:0];
                     w_acc_data = i_mem_wr_data;
                  end else begin
                     w_state_d = StWait;
                     w_cnt_d   = LAT_M1;
                  end
               end else begin
                  w_err_d = 1'b1;
               end
            end
         end
      endcase
   end

   // Access datapath: load extraction and store lane steering.
   assign w_idx  = w_acc_addr[AW-1:2];
   assign w_off  = w_acc_addr[1:0];
   assign w_word = r_mem[w_idx];
   assign w_byte = w_word[{w_off, 3'b000} +: 8];
   assign w_half = w_acc_addr[1] ? w_word[31:16] : w_word[15:0];

   // Build the extended load value and the store byte enables.
   always_comb begin
      w_load_val   = 32'd0;
      w_store_word = w_acc_data;
      w_be         = 4'b0000;
      case (w_acc_op)
         OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  w_load_val = {24'd0, w_byte};
         OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
         OP_LHU:  w_load_val = {16'd0, w_half};
         OP_LW:   w_load_val = w_word;
         OP_SB: begin
            w_store_word = {4{w_acc_data[7:0]}};
            w_be         = 4'b0001 << w_off;
         end
         OP_SH: begin
            w_store_word = {2{w_acc_data[15:0]}};
            w_be         = w_off[1] ? 4'b1100 : 4'b0011;
         end
         OP_SW:   w_be = 4'b1111;
         default: w_load_val = 32'd0;
      endcase
   end

   // Byte-enabled array write; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (w_access && w_acc_op[3] && !i_rst) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_store_word[8*b +: 8];
         end
      end
   end

   // Control state, latched request and registered response pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= StIdle;
         r_cnt      <= 4'd0;
         r_op       <= 4'd0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_rd_ready <= 1'b0;
         r_rd_data  <= 32'd0;
         r_wr_ready <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_latch) begin
            r_op    <= i_mem_op;
            r_addr  <= i_mem_addr[AW-1:0];
            r_wdata <= i_mem_wr_data;
         end
         r_rd_ready <= w_access & ~w_acc_op[3];
         r_rd_data  <= (w_access & ~w_acc_op[3]) ? w_load_val : 32'd0;
         r_wr_ready <= w_access & w_acc_op[3];
         r_err      <= w_err_d;
      end
   end

   assign o_mem_rd_ready = r_rd_ready;
   assign o_mem_rd_data  = r_rd_data;
   assign o_mem_wr_ready = r_wr_ready;
   assign o_busy         = (r_state == StWait);
   assign o_err          = r_err;

endmodule

// File: tb/tb_lsq_dmem_responder.sv
// Bench for lsq_dmem_responder: three instances (LATENCY 2, 3, 1) driven by directed
// vectors, a per-cycle reference model, and hand-computed literal expectations.
module tb_lsq_dmem_responder;

   localparam logic [3:0] LB = 4'b0001, LH = 4'b0010, LW = 4'b0011, LBU = 4'b0100;
   localparam logic [3:0] LHU = 4'b0101, SB = 4'b1001, SH = 4'b1010, SW = 4'b1011;
   localparam int         WORDS = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  op [3];
   logic [31:0] ad [3];
   logic [31:0] wd [3];
   logic        rd_rdy [3];
   logic        wr_rdy [3];
   logic        busy [3];
   logic        err [3];
   logic [31:0] rd_data [3];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      lsq_dmem_responder #(
         .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 3 : 1)),
         .DEPTH_LOG2(6),
         .INIT_FILE ("")
      ) u_dut (
         .i_clk         (clk),
         .i_rst         (rst),
         .i_mem_op      (op[g]),
         .i_mem_addr    (ad[g]),
         .i_mem_wr_data (wd[g]),
         .o_mem_rd_ready(rd_rdy[g]),
         .o_mem_rd_data (rd_data[g]),
         .o_mem_wr_ready(wr_rdy[g]),
         .o_busy        (busy[g]),
         .o_err         (err[g])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
   endfunction

   // Negedge (counted from the driving negedge) on which the ready pulse is visible.
   function automatic int resp_neg(input int k);
      return (lat_of(k) == 1) ? 1 : lat_of(k) + 1;
   endfunction

   function automatic int size_of(input logic [3:0] o);
      if (o == LB || o == LBU || o == SB) return 1;
      if (o == LH || o == LHU || o == SH) return 2;
      return 4;
   endfunction

   function automatic bit legal(input logic [3:0] o);
      return o inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] mm [3][WORDS];
   bit          pend [3];
   int          due [3];
   logic [3:0]  p_op [3];
   logic [31:0] p_addr [3];
   logic [31:0] p_data [3];
   logic        e_rd [3], e_wr [3], e_busy [3], e_err [3];
   logic [31:0] e_data [3];
   int          edge_n = 0;

   task automatic model_exec(input int k);
      int          idx, off, sz;
      logic [31:0] w, v;
      idx = int'(p_addr[k] >> 2) % WORDS;
      off = int'(p_addr[k] % 4);
      sz  = size_of(p_op[k]);
      w   = mm[k][idx];
      if (p_op[k][3]) begin
         for (int i = 0; i < sz; i++) w[8*(off+i) +: 8] = p_data[k][8*i +: 8];
         mm[k][idx] = w;
         e_wr[k]    = 1'b1;
      end else begin
         v = w >> (8 * off);
         if (sz == 1) begin
            v = v & 32'h0000_00FF;
            if (p_op[k] == LB && v[7]) v = v | 32'hFFFF_FF00;
         end else if (sz == 2) begin
            v = v & 32'h0000_FFFF;
            if (p_op[k] == LH && v[15]) v = v | 32'hFFFF_0000;
         end
         e_rd[k]   = 1'b1;
         e_data[k] = v;
      end
   endtask

   always @(posedge clk) begin
      edge_n++;
      for (int k = 0; k < 3; k++) begin
         e_rd[k] = 1'b0; e_wr[k] = 1'b0; e_err[k] = 1'b0; e_data[k] = 32'd0;
         if (rst) begin
            pend[k]   = 1'b0;
            e_busy[k] = 1'b0;
         end else begin
            if (op[k] != 4'd0) begin
               if (pend[k]) e_err[k] = 1'b1;
               else if (!legal(op[k]) || (int'(ad[k] % 4) % size_of(op[k])) != 0) e_err[k] = 1'b1;
               else begin
                  pend[k]   = 1'b1;
                  due[k]    = edge_n + ((lat_of(k) == 1) ? 0 : lat_of(k));
                  p_op[k]   = op[k];
                  p_addr[k] = ad[k];
                  p_data[k] = wd[k];
               end
            end
            if (pend[k] && due[k] == edge_n) begin
               model_exec(k);
               pend[k] = 1'b0;
            end
            e_busy[k] = pend[k];
         end
      end
   end

   // Per-cycle comparison of every instance against the model.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (rd_rdy[k] !== e_rd[k] || rd_data[k] !== e_data[k] || wr_rdy[k] !== e_wr[k] ||
                busy[k] !== e_busy[k] || err[k] !== e_err[k]) begin
               n_fail++;
               $display("FAIL model inst%0d edge%0d: got rd=%b data=%h wr=%b busy=%b err=%b want rd=%b data=%h wr=%b busy=%b err=%b",
                        k, edge_n, rd_rdy[k], rd_data[k], wr_rdy[k], busy[k], err[k],
                        e_rd[k], e_data[k], e_wr[k], e_busy[k], e_err[k]);
            end
         end
      end
   end

   // ---------------- literal checks and stimulus ----------------
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   // Issue one accepted request at the current negedge and check its pulse placement.
   task automatic txn(input int k, input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                      input logic er, input logic ew, input logic [31:0] edata, input string nm);
      op[k] = o; ad[k] = a; wd[k] = d;
      @(negedge clk);
      op[k] = 4'd0;
      for (int i = 1; i < resp_neg(k); i++) begin
         chk({nm, " early"}, {rd_rdy[k], wr_rdy[k]}, 64'd0);
         @(negedge clk);
      end
      chk({nm, " pulse"}, {rd_rdy[k], wr_rdy[k], rd_data[k]}, {er, ew, edata});
      @(negedge clk);
      chk({nm, " width"}, {rd_rdy[k], wr_rdy[k]}, 64'd0);
   endtask

   // Issue a request that must be rejected: err pulse, no ready pulse.
   task automatic rej(input int k, input logic [3:0] o, input logic [31:0] a, input string nm);
      op[k] = o; ad[k] = a; wd[k] = 32'hFFFF_FFFF;
      @(negedge clk);
      op[k] = 4'd0;
      chk({nm, " err"}, err[k], 1'b1);
      for (int i = 0; i <= resp_neg(k); i++) begin
         @(negedge clk);
         chk({nm, " noresp"}, {rd_rdy[k], wr_rdy[k], err[k]}, 64'd0);
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         op[k] = 4'd0; ad[k] = 32'd0; wd[k] = 32'd0; pend[k] = 1'b0;
         for (int w = 0; w < WORDS; w++) mm[k][w] = 32'd0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++)
         chk("reset state", {rd_rdy[k], wr_rdy[k], busy[k], err[k], rd_data[k]}, 64'd0);
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // LATENCY=2 instance: basic access, extension, byte lanes, rejection, aliasing.
      txn(0, SW,  32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, "A sw");
      txn(0, LW,  32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, "A lw");
      txn(0, LB,  32'h13, 32'h0, 1'b1, 1'b0, 32'hFFFFFFDE, "A lb");
      txn(0, LBU, 32'h13, 32'h0, 1'b1, 1'b0, 32'h000000DE, "A lbu");
      txn(0, LH,  32'h10, 32'h0, 1'b1, 1'b0, 32'hFFFFBEEF, "A lh");
      txn(0, LHU, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000DEAD, "A lhu");
      txn(0, SB,  32'h11, 32'h000000AA, 1'b0, 1'b1, 32'h0, "A sb");
      txn(0, LW,  32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADAAEF, "A lw after sb");
      rej(0, LH,  32'h11, "A lh misaligned");
      rej(0, SW,  32'h12, "A sw misaligned");
      rej(0, 4'b0111, 32'h10, "A illegal op");
      txn(0, LW,  32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADAAEF, "A lw unchanged");
      txn(0, LW,  32'h110, 32'h0, 1'b1, 1'b0, 32'hDEADAAEF, "A lw alias");
      txn(0, SH,  32'h12, 32'hFFFF5678, 1'b0, 1'b1, 32'h0, "A sh");
      txn(0, LW,  32'h10, 32'h0, 1'b1, 1'b0, 32'h5678AAEF, "A lw after sh");

      // LATENCY=3 instance: overrun while busy, then accept during RESP.
      txn(1, SW, 32'h20, 32'h12345678, 1'b0, 1'b1, 32'h0, "B sw");
      op[1] = LW; ad[1] = 32'h20;
      @(negedge clk);
      chk("B busy", busy[1], 1'b1);
      op[1] = SW; wd[1] = 32'hFFFFFFFF;
      @(negedge clk);
      chk("B overrun err", err[1], 1'b1);
      op[1] = 4'd0;
      @(negedge clk);
      chk("B not early", rd_rdy[1], 1'b0);
      @(negedge clk);
      chk("B lw on time", {rd_rdy[1], rd_data[1]}, {1'b1, 32'h12345678});
      op[1] = LW; ad[1] = 32'h20;
      @(negedge clk);
      op[1] = 4'd0;
      chk("B resp accept", {rd_rdy[1], busy[1], err[1]}, 64'b010);
      repeat (3) @(negedge clk);
      chk("B second lw", {rd_rdy[1], rd_data[1]}, {1'b1, 32'h12345678});
      @(negedge clk);
      chk("B second width", rd_rdy[1], 1'b0);

      // Async reset in the middle of WAIT abandons the request.
      op[1] = LW; ad[1] = 32'h20;
      @(negedge clk);
      op[1] = 4'd0;
      @(negedge clk);
      chk("B busy before rst", busy[1], 1'b1);
      rst = 1'b1;
      #1;
      chk("B async rst", {busy[1], rd_rdy[1], wr_rdy[1], err[1]}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("B no resp after rst", {rd_rdy[1], busy[1]}, 64'd0);
      end

      // LATENCY=1 instance: back-to-back requests give a pulse every cycle.
      op[2] = SW; ad[2] = 32'h0; wd[2] = 32'h11111111;
      @(negedge clk);
      chk("C b2b 0", wr_rdy[2], 1'b1);
      op[2] = SW; ad[2] = 32'h4; wd[2] = 32'h22222222;
      @(negedge clk);
      chk("C b2b 1", wr_rdy[2], 1'b1);
      op[2] = LW; ad[2] = 32'h0;
      @(negedge clk);
      chk("C b2b 2", {rd_rdy[2], rd_data[2]}, {1'b1, 32'h11111111});
      op[2] = LW; ad[2] = 32'h4;
      @(negedge clk);
      chk("C b2b 3", {rd_rdy[2], rd_data[2]}, {1'b1, 32'h22222222});
      op[2] = 4'd0;
      @(negedge clk);
      chk("C idle", {rd_rdy[2], wr_rdy[2], busy[2]}, 64'd0);
      txn(2, LHU, 32'h6, 32'h0, 1'b1, 1'b0, 32'h00002222, "C lhu");

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
